// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared address geometry and FSM encoding for the data cache
package dcache_pkg;

   localparam int OFF_W  = 2;
   localparam int IDX_W  = 3;
   localparam int TAG_W  = 11;
   localparam int LINE_W = OFF_W + IDX_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2
   } state_t;

endpackage

// File: rtl/dcache_data_array.sv
// rtl/dcache_data_array.sv - cache word storage, one write port and one combinational read port
module dcache_data_array #(
   parameter int DEPTH = 32,
   parameter int DW    = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we)
         mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/dcache.sv
// rtl/dcache.sv - direct-mapped write-through no-write-allocate data cache
module dcache
   import dcache_pkg::*;
#(
   parameter int LINES = 8,
   parameter int WORDS = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_dataout,
   input  logic        d_we,
   input  logic        d_re,
   output logic [15:0] d_datain,
   output logic        hit,
   output logic        m_req,
   output logic        m_we,
   output logic [15:0] m_addr,
   output logic [15:0] m_wdata,
   input  logic [15:0] m_rdata,
   input  logic        m_ack
);

   localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

   state_t             state;
   logic [OFF_W-1:0]   cnt;
   logic [LINES-1:0]   valid;
   logic [TAG_W-1:0]   tags [LINES];

   logic [IDX_W-1:0]   d_idx, m_idx;
   logic [TAG_W-1:0]   d_tag, m_tag;
   logic               lookup_hit, m_line_hit;
   logic               arr_we;
   logic [15:0]        arr_wdata;

   assign d_idx      = d_addr[LINE_W-1:OFF_W];
   assign d_tag      = d_addr[15:LINE_W];
   assign m_idx      = m_addr[LINE_W-1:OFF_W];
   assign m_tag      = m_addr[15:LINE_W];
   assign lookup_hit = valid[d_idx] && (tags[d_idx] == d_tag);
   assign m_line_hit = valid[m_idx] && (tags[m_idx] == m_tag);

   // m_addr already points at the word being filled or stored, so it doubles as the write address
   always_comb begin
      arr_we    = 1'b0;
      arr_wdata = m_rdata;
      if (state == FILL && m_ack) begin
         arr_we = 1'b1;
      end else if (state == WRITE && m_ack && m_line_hit) begin
         arr_we    = 1'b1;
         arr_wdata = m_wdata;
      end
   end

   always_comb begin
      hit = 1'b0;
      if (reset)
         hit = ~(d_re | d_we);
      else begin
         case (state)
            IDLE:    hit = d_we ? 1'b0 : (d_re ? lookup_hit : 1'b1);
            WRITE:   hit = m_ack;
            default: hit = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         valid   <= '0;
         m_req   <= 1'b0;
         m_we    <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (d_we) begin
                  state   <= WRITE;
                  m_req   <= 1'b1;
                  m_we    <= 1'b1;
                  m_addr  <= d_addr;
                  m_wdata <= d_dataout;
               end else if (d_re && !lookup_hit) begin
                  state  <= FILL;
                  cnt    <= '0;
                  m_req  <= 1'b1;
                  m_we   <= 1'b0;
                  m_addr <= {d_addr[15:OFF_W], {OFF_W{1'b0}}};
               end
            end
            FILL: begin
               if (m_ack) begin
                  cnt                 <= cnt + 1'b1;
                  m_addr[OFF_W-1:0]   <= cnt + 1'b1;
                  if (cnt == LAST_WORD) begin
                     valid[m_idx] <= 1'b1;
                     state        <= IDLE;
                     m_req        <= 1'b0;
                  end
               end
            end
            WRITE: begin
               if (m_ack) begin
                  state <= IDLE;
                  m_req <= 1'b0;
                  m_we  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (state == FILL && m_ack && cnt == LAST_WORD)
         tags[m_idx] <= m_tag;
   end

   dcache_data_array #(
      .DEPTH (LINES * WORDS),
      .DW    (16)
   ) u_data (
      .clock (clock),
      .we    (arr_we),
      .waddr (m_addr[LINE_W-1:0]),
      .wdata (arr_wdata),
      .raddr (d_addr[LINE_W-1:0]),
      .rdata (d_datain)
   );

endmodule
